// File: rtl/audio_pkg.sv
// Shared constants for the audio-through path, I2S transmit side.
// Optional feature macro used by consumers of this package: UNDERRUN_MUTE_EN.
package audio_pkg;

    localparam int         DATA_W_DEFAULT = 24;
    localparam int         SLOT_BITS      = 32;
    localparam int         MCLK_PER_BCLK  = 4;
    localparam logic [7:0] PH_LEFT_LOAD   = 8'h00;
    localparam logic [7:0] PH_RIGHT_LOAD  = 8'h80;

    localparam int SLOT_W   = $clog2(SLOT_BITS);
    localparam int BCLK_BIT = $clog2(MCLK_PER_BCLK) - 1;

    // Slot 0 is the one-BCLK gap after the LRCK edge; slots past the word are padding.
    function automatic logic slot_has_data(input logic [SLOT_W-1:0] b, input int data_w);
        return (b != '0) && (int'(b) <= data_w);
    endfunction

endpackage

// File: rtl/i2s_tx_timing.sv
// Free-running I2S master timing: 8-bit phase counter, registered BCLK/LRCK/FRAME_START,
// plus the combinational slot index and per-channel load enables for the datapath.
module i2s_tx_timing
    import audio_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_bclk,
    output logic              o_lrck,
    output logic              o_frame_start,
    output logic              o_chan,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_load_l,
    output logic              o_load_r
);

    logic [7:0] r_ph;
    logic       r_bclk;
    logic       r_lrck;
    logic       r_frame_start;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ph          <= 8'h00;
            r_bclk        <= 1'b0;
            r_lrck        <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_ph          <= r_ph + 8'd1;
            r_bclk        <= r_ph[BCLK_BIT];
            r_lrck        <= r_ph[7];
            r_frame_start <= (r_ph == PH_LEFT_LOAD);
        end
    end

    assign o_bclk        = r_bclk;
    assign o_lrck        = r_lrck;
    assign o_frame_start = r_frame_start;

    // Unregistered view of the current phase; the datapath registers what it derives from it.
    assign o_chan   = r_ph[7];
    assign o_slot   = r_ph[BCLK_BIT+1 +: SLOT_W];
    assign o_load_l = (r_ph == PH_LEFT_LOAD);
    assign o_load_r = (r_ph == PH_RIGHT_LOAD);

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: hold/shift datapath around the i2s_tx_timing phase generator.
// Define UNDERRUN_MUTE_EN to mute and flag slots whose channel saw no strobe since the last load.
module i2s_tx_serializer
    import audio_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] DATA_LEFT_IN,
    input  logic [DATA_W-1:0] DATA_RIGHT_IN,
    input  logic              SAMPLING_POINT_LEFT_IN,
    input  logic              SAMPLING_POINT_RIGHT_IN,
    output logic              I2S_BCLK,
    output logic              I2S_LRCK,
    output logic              I2S_SDATA,
    output logic              FRAME_START,
    output logic              UNDERRUN
);

    localparam int IDX_W = $clog2(DATA_W);

    logic              w_chan;
    logic [SLOT_W-1:0] w_slot;
    logic              w_load_l;
    logic              w_load_r;
    logic              w_mute_l;
    logic              w_mute_r;
    logic              w_bit_on;
    logic [IDX_W-1:0]  w_idx;
    logic              w_bit;

    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_hold_r;
    logic [DATA_W-1:0] r_sh_l;
    logic [DATA_W-1:0] r_sh_r;
    logic              r_sdata;

    i2s_tx_timing u_timing (
        .i_clk         (MCLK),
        .i_rst         (RESET),
        .o_bclk        (I2S_BCLK),
        .o_lrck        (I2S_LRCK),
        .o_frame_start (FRAME_START),
        .o_chan        (w_chan),
        .o_slot        (w_slot),
        .o_load_l      (w_load_l),
        .o_load_r      (w_load_r)
    );

`ifdef UNDERRUN_MUTE_EN
    logic r_fresh_l;
    logic r_fresh_r;
    logic r_underrun;

    // A strobe landing in the load cycle wins over the clear, so it arms the following slot.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            r_fresh_l  <= 1'b0;
            r_fresh_r  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_fresh_l  <= SAMPLING_POINT_LEFT_IN  | (r_fresh_l & ~w_load_l);
            r_fresh_r  <= SAMPLING_POINT_RIGHT_IN | (r_fresh_r & ~w_load_r);
            r_underrun <= (w_load_l & ~r_fresh_l) | (w_load_r & ~r_fresh_r);
        end
    end

    assign w_mute_l = ~r_fresh_l;
    assign w_mute_r = ~r_fresh_r;
    assign UNDERRUN = r_underrun;
`else
    assign w_mute_l = 1'b0;
    assign w_mute_r = 1'b0;
    assign UNDERRUN = 1'b0;
`endif

    // Slot b carries word bit DATA_W-b; the index is only consumed when w_bit_on is set.
    assign w_bit_on = slot_has_data(w_slot, DATA_W);
    assign w_idx    = IDX_W'(DATA_W - int'(w_slot));

    always_comb begin
        w_bit = 1'b0;
        if (w_bit_on) begin
            w_bit = w_chan ? r_sh_r[w_idx] : r_sh_l[w_idx];
        end
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_sh_l   <= '0;
            r_sh_r   <= '0;
            r_sdata  <= 1'b0;
        end else begin
            if (SAMPLING_POINT_LEFT_IN) begin
                r_hold_l <= DATA_LEFT_IN;
            end
            if (SAMPLING_POINT_RIGHT_IN) begin
                r_hold_r <= DATA_RIGHT_IN;
            end
            // Loads sample the hold value from before this edge, so a same-cycle strobe waits a frame.
            if (w_load_l) begin
                r_sh_l <= w_mute_l ? '0 : r_hold_l;
            end
            if (w_load_r) begin
                r_sh_r <= w_mute_r ? '0 : r_hold_r;
            end
            r_sdata <= w_bit;
        end
    end

    assign I2S_SDATA = r_sdata;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer: per-cycle reference model, directed frame table,
// asynchronous reset mid-frame, and randomized strobes. Follows UNDERRUN_MUTE_EN if defined.
module tb_i2s_tx_serializer;

    localparam int DW = 24;

`ifdef UNDERRUN_MUTE_EN
    localparam bit REPEATS = 1'b0;
`else
    localparam bit REPEATS = 1'b1;
`endif

    logic          MCLK = 1'b0;
    logic          RESET;
    logic [DW-1:0] DATA_LEFT_IN;
    logic [DW-1:0] DATA_RIGHT_IN;
    logic          SAMPLING_POINT_LEFT_IN;
    logic          SAMPLING_POINT_RIGHT_IN;
    logic          I2S_BCLK;
    logic          I2S_LRCK;
    logic          I2S_SDATA;
    logic          FRAME_START;
    logic          UNDERRUN;

    always #5 MCLK = ~MCLK;

    i2s_tx_serializer #(.DATA_W(DW)) dut (
        .MCLK                    (MCLK),
        .RESET                   (RESET),
        .DATA_LEFT_IN            (DATA_LEFT_IN),
        .DATA_RIGHT_IN           (DATA_RIGHT_IN),
        .SAMPLING_POINT_LEFT_IN  (SAMPLING_POINT_LEFT_IN),
        .SAMPLING_POINT_RIGHT_IN (SAMPLING_POINT_RIGHT_IN),
        .I2S_BCLK                (I2S_BCLK),
        .I2S_LRCK                (I2S_LRCK),
        .I2S_SDATA               (I2S_SDATA),
        .FRAME_START             (FRAME_START),
        .UNDERRUN                (UNDERRUN)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: m_k counts rising edges since reset release.
    int unsigned   m_k;
    logic [DW-1:0] m_hold_l, m_hold_r, m_word_l, m_word_r;
    logic          m_fresh_l, m_fresh_r;

    // Receiver that deserialises SDATA on BCLK rising edges, framed by FRAME_START.
    logic          prev_bclk;
    int            bitcnt;
    logic [31:0]   rx_l, rx_r;
    logic [31:0]   q_l[$];
    logic [31:0]   q_r[$];

    typedef struct {
        logic [DW-1:0] pre_l;
        logic [DW-1:0] pre_r;
        int            st_ph;
        logic [DW-1:0] st_val;
        logic [31:0]   e_l0;
        logic [31:0]   e_r0;
        logic [31:0]   e_l1;
        logic [31:0]   e_r1;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] slot(input logic [DW-1:0] w);
        return {1'b0, w, 7'b0};
    endfunction

    function automatic logic [31:0] rep(input logic [DW-1:0] w);
        return REPEATS ? slot(w) : 32'h0;
    endfunction

    function automatic logic exp_bit(input logic [DW-1:0] w, input int b);
        if (b >= 1 && b <= DW) return w[DW-b];
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_k       = 0;
        m_hold_l  = '0;
        m_hold_r  = '0;
        m_word_l  = '0;
        m_word_r  = '0;
        m_fresh_l = 1'b0;
        m_fresh_r = 1'b0;
        bitcnt    = 64;
        prev_bclk = 1'b0;
        q_l.delete();
        q_r.delete();
    endtask

    // One MCLK cycle: drive at the falling edge, advance the model at the rising edge,
    // compare every output at the next falling edge.
    task automatic tick(input logic s_l, input logic [DW-1:0] v_l,
                        input logic s_r, input logic [DW-1:0] v_r);
        int   p;
        int   b;
        logic und;
        logic e_bclk, e_lrck, e_sd, e_fs;
        SAMPLING_POINT_LEFT_IN  = s_l;
        SAMPLING_POINT_RIGHT_IN = s_r;
        DATA_LEFT_IN            = s_l ? v_l : DW'($urandom);
        DATA_RIGHT_IN           = s_r ? v_r : DW'($urandom);
        @(posedge MCLK);
        p   = int'(m_k % 256);
        und = 1'b0;
        if (p == 0) begin
            und       = !REPEATS && !m_fresh_l;
            m_word_l  = (REPEATS || m_fresh_l) ? m_hold_l : '0;
            m_fresh_l = 1'b0;
        end
        if (p == 128) begin
            und       = !REPEATS && !m_fresh_r;
            m_word_r  = (REPEATS || m_fresh_r) ? m_hold_r : '0;
            m_fresh_r = 1'b0;
        end
        if (s_l) begin m_hold_l = v_l; m_fresh_l = 1'b1; end
        if (s_r) begin m_hold_r = v_r; m_fresh_r = 1'b1; end
        b      = (p / 4) % 32;
        e_bclk = ((p / 2) % 2) != 0;
        e_lrck = p >= 128;
        e_sd   = exp_bit((p >= 128) ? m_word_r : m_word_l, b);
        e_fs   = (p == 0);
        m_k++;
        @(negedge MCLK);
        check("outputs{bclk,lrck,sdata,fs,underrun}",
              {27'd0, I2S_BCLK, I2S_LRCK, I2S_SDATA, FRAME_START, UNDERRUN},
              {27'd0, e_bclk, e_lrck, e_sd, e_fs, und});
        if (FRAME_START) bitcnt = 0;
        if (I2S_BCLK && !prev_bclk && bitcnt < 64) begin
            if (bitcnt < 32) rx_l = {rx_l[30:0], I2S_SDATA};
            else             rx_r = {rx_r[30:0], I2S_SDATA};
            bitcnt++;
            if (bitcnt == 64) begin
                q_l.push_back(rx_l);
                q_r.push_back(rx_r);
            end
        end
        prev_bclk = I2S_BCLK;
    endtask

    task automatic idle_to(input int ph);
        for (int i = 0; i < 300 && int'(m_k % 256) != ph; i++) tick(1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        RESET                   = 1'b1;
        SAMPLING_POINT_LEFT_IN  = 1'b0;
        SAMPLING_POINT_RIGHT_IN = 1'b0;
        DATA_LEFT_IN            = '0;
        DATA_RIGHT_IN           = '0;
        rx_l                    = '0;
        rx_r                    = '0;
        model_reset();

        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, -1,    24'h0,
                    32'h52D2D280, 32'h2D2D2D00,
                    REPEATS ? 32'h52D2D280 : 32'h0, REPEATS ? 32'h2D2D2D00 : 32'h0};
        vecs[1] = '{24'h000001, 24'h000000, 8'h00, 24'h123456,
                    slot(24'h000001), 32'h0, slot(24'h123456), 32'h0};
        vecs[2] = '{24'h000000, 24'h00ABCD, 8'h20, 24'hFFFFFF,
                    32'h0, slot(24'h00ABCD), slot(24'hFFFFFF), rep(24'h00ABCD)};
        vecs[3] = '{24'h654321, 24'hC0FFEE, 8'h7C, 24'h800001,
                    slot(24'h654321), slot(24'hC0FFEE), slot(24'h800001), rep(24'hC0FFEE)};
        vecs[4] = '{24'hFFFFFF, 24'h13579B, 8'h80, 24'h000002,
                    slot(24'hFFFFFF), slot(24'h13579B), slot(24'h000002), rep(24'h13579B)};

        #1;
        check("reset_outputs", {27'd0, I2S_BCLK, I2S_LRCK, I2S_SDATA, FRAME_START, UNDERRUN}, 32'h0);
        repeat (3) @(negedge MCLK);
        check("reset_held_outputs", {27'd0, I2S_BCLK, I2S_LRCK, I2S_SDATA, FRAME_START, UNDERRUN}, 32'h0);
        RESET = 1'b0;

        // Link timing with no strobes at all.
        for (int i = 0; i < 1024; i++) tick(1'b0, '0, 1'b0, '0);
        check("idle_frames_seen", q_l.size(), 4);

        // Directed frames: preload before ph=0, optional left strobe at st_ph in frame A.
        for (int v = 0; v < 5; v++) begin
            idle_to(8'hF0);
            tick(1'b1, vecs[v].pre_l, 1'b0, '0);
            tick(1'b0, '0, 1'b1, vecs[v].pre_r);
            idle_to(8'h00);
            q_l.delete();
            q_r.delete();
            for (int i = 0; i < 520; i++) begin
                if (i < 256 && int'(m_k % 256) == vecs[v].st_ph)
                    tick(1'b1, vecs[v].st_val, 1'b0, '0);
                else
                    tick(1'b0, '0, 1'b0, '0);
            end
            check($sformatf("vec%0d_frames_captured", v), (q_l.size() >= 2) ? 1 : 0, 1);
            if (q_l.size() >= 2) begin
                check($sformatf("vec%0d_frameA_left", v),  q_l[0], vecs[v].e_l0);
                check($sformatf("vec%0d_frameA_right", v), q_r[0], vecs[v].e_r0);
                check($sformatf("vec%0d_frameB_left", v),  q_l[1], vecs[v].e_l1);
                check($sformatf("vec%0d_frameB_right", v), q_r[1], vecs[v].e_r1);
            end
        end

        // Asynchronous reset between edges at ph=0x9C while holds are non-zero.
        idle_to(8'h9C);
        #2;
        RESET = 1'b1;
        #1;
        check("async_reset_outputs", {27'd0, I2S_BCLK, I2S_LRCK, I2S_SDATA, FRAME_START, UNDERRUN}, 32'h0);
        repeat (2) @(negedge MCLK);
        check("async_reset_held", {27'd0, I2S_BCLK, I2S_LRCK, I2S_SDATA, FRAME_START, UNDERRUN}, 32'h0);
        RESET = 1'b0;
        model_reset();
        for (int i = 0; i < 260; i++) tick(1'b0, '0, 1'b0, '0);
        check("post_reset_frame_captured", (q_l.size() >= 1) ? 1 : 0, 1);
        if (q_l.size() >= 1) begin
            check("post_reset_left_zero",  q_l[0], 32'h0);
            check("post_reset_right_zero", q_r[0], 32'h0);
        end

        // Randomized strobes with a per-segment rate, from dense to starved.
        for (int seg = 0; seg < 12; seg++) begin
            int rate;
            case ($urandom_range(0, 2))
                0:       rate = 2;
                1:       rate = 16;
                default: rate = 400;
            endcase
            for (int i = 0; i < 256; i++)
                tick($urandom_range(0, rate - 1) == 0, DW'($urandom),
                     $urandom_range(0, rate - 1) == 0, DW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
Downstream stage of the audio-through path. It takes the parallel 24-bit left/right words and their one-cycle sampling strobes, and serialises them onto a standard Philips I2S link for the DAC/codec. The 12.288 MHz MCLK domain gives BCLK = MCLK/4 (3.072 MHz) and LRCK = MCLK/256 (48 kHz), with 32-bit slots per channel. The block is a free-running master: the link timing never depends on when the strobes arrive.

Parameters:
DATA_W, 24, audio word width in bits; legal range 16..31; MSB-first, zero-padded within the 32-bit slot.

Ports:
MCLK  in  1  12.288 MHz system clock; all logic is on the rising edge.
RESET  in  1  reset; asynchronous, active-high.
DATA_LEFT_IN  in  DATA_W  left sample; valid only while SAMPLING_POINT_LEFT_IN=1.
DATA_RIGHT_IN  in  DATA_W  right sample; valid only while SAMPLING_POINT_RIGHT_IN=1.
SAMPLING_POINT_LEFT_IN  in  1  one-cycle strobe that captures DATA_LEFT_IN.
SAMPLING_POINT_RIGHT_IN  in  1  one-cycle strobe that captures DATA_RIGHT_IN.
I2S_BCLK  out  1  bit clock, MCLK/4, 50% duty.
I2S_LRCK  out  1  word select; 0 = left, 1 = right.
I2S_SDATA  out  1  serial data, MSB first.
FRAME_START  out  1  one-cycle pulse when a left slot begins.
UNDERRUN  out  1  one-cycle pulse on a stale-slot load; constant 0 unless UNDERRUN_MUTE_EN is defined.

Behaviour:
- Phase counter ph[7:0]:
  - Reset value 0; increments by 1 every MCLK; wraps 0xFF -> 0x00.
  - ph[7] selects the channel; ph[6:2] is the bit slot b (0..31); ph[1] is the BCLK phase.
- Registered outputs, 1-cycle latency: output value at cycle t+1 is a function of ph(t).
  - I2S_BCLK = ph[1]. SDATA therefore changes on BCLK falling edges and is stable on rising edges.
  - I2S_LRCK = ph[7].
  - I2S_SDATA in slot b: 0 when b = 0; word bit [DATA_W-b] when 1 <= b <= DATA_W; 0 when b > DATA_W. This places the MSB one BCLK after each LRCK edge.
  - FRAME_START = 1 iff ph = 0x00.
- Hold registers hold_l and hold_r:
  - Reset value 0.
  - Loaded from the DATA_*_IN bus on the corresponding strobe.
  - If a strobe repeats before the next slot, the latest value wins.
- Slot shift registers:
  - sh_l is loaded from hold_l when ph = 0x00; sh_r is loaded from hold_r when ph = 0x80.
  - The shift register, not the hold register, drives SDATA for the whole slot, so an input update mid-slot never corrupts the slot in progress.
- Strobe in the same cycle as the slot load: the load takes the OLD hold value. The new value goes out in the next frame (no bypass).
- No new strobe since the last load (default build): the previous word is repeated.
- Both strobes in the same cycle: both hold registers update independently.
- RESET asserted mid-frame, asynchronous:
  - ph, hold, shift and all outputs go to 0 immediately.
  - After release, the first FRAME_START occurs at the cycle after the first post-reset rising edge.
  - The first frame transmits zeros.
- Arithmetic: ph is 8-bit modulo. There is no data arithmetic; bits pass through unchanged.

Optional Feature:
Macro UNDERRUN_MUTE_EN.
- Defined:
  - Each channel has a fresh flag: reset 0, set by that channel's strobe, cleared at that channel's slot load.
  - A strobe in the load cycle sets the flag for the next slot.
  - If the flag is 0 at load time, the shift register loads 0 (mute) and UNDERRUN pulses for one cycle, aligned with the ph = 0x00 or 0x80 load cycle + 1.
- Undefined: no flags exist, stale words repeat, and UNDERRUN is tied to 0.

Decomposition:
- Shared package audio_pkg:
  - DATA_W default;
  - SLOT_BITS = 32;
  - MCLK_PER_BCLK = 4;
  - PH_LEFT_LOAD = 8'h00;
  - PH_RIGHT_LOAD = 8'h80.
- Sub-module i2s_tx_timing: ph counter plus decoding of registered BCLK/LRCK/FRAME_START, slot index b, and the load enables. The top module keeps the hold/shift/mute datapath.

Test Plan:
1. Timing after reset: release RESET, run 1024 cycles -> I2S_BCLK period 4 MCLK (2 high, 2 low), I2S_LRCK period 256 with edges exactly 128 apart, FRAME_START every 256 cycles, coincident with the LRCK falling edge.
2. Data pattern: strobe L = 0xA5A5A5 and R = 0x5A5A5A before ph = 0x00 -> sample SDATA on BCLK rising edges. Left slot reads 0, then 1010_0101 x3, then 7 zeros; right slot reads 0, then 0101_1010 x3, then 7 zeros.
3. Load collision: strobe L = 0x123456 in the exact ph = 0x00 load cycle, with hold_l = 0x000001 -> the current frame sends 0x000001 and the next frame sends 0x123456.
4. Mid-slot update: strobe L = 0xFFFFFF at ph = 0x20 while 0x000000 is shifting -> the current left slot stays all zeros; the next frame sends 0xFFFFFF.
5. Reset mid-frame: assert RESET at ph = 0x9C asynchronously between edges -> all outputs 0 before the next edge. After release, FRAME_START occurs 1 cycle after the first edge and the first frame data is 0.
6. UNDERRUN_MUTE_EN build: strobe L = 0x7FFFFF once, then no further strobes -> frame 1 sends 0x7FFFFF, frame 2 sends zeros with an UNDERRUN pulse at the ph = 0x01 cycle. The default build instead repeats 0x7FFFFF and UNDERRUN stays 0.
